inst_mem_loadable: RTL and testbench

Parametrised, synchronous-read instruction memory for the pipelined MIPS CPU's IF stage. It replaces the fixed combinational ROM with a RAM that software or a boot loader can fill word-by-word at run time. Fetch returns data one cycle after request and honours a pipeline stall. Misaligned and out-of-range fetches return a configurable NOP word.

---
 rtl/inst_mem_loadable.sv | 151 +++++++++++++++
 tb/tb_inst_mem_loadable.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loadable.sv
// Loadable synchronous-read instruction memory for the IF stage.
// A boot loader streams words in through the ld_* handshake; the IF stage
// fetches with one-cycle latency, honouring stalls, and gets NOP_WORD for
// misaligned, out-of-range or blocked fetches.
module inst_mem_loadable #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  if_req_i,
    input  logic [31:0]           if_addr_i,
    input  logic                  if_stall_i,
    output logic [31:0]           if_inst_o,
    output logic                  if_valid_o,
    output logic                  if_misaligned_o,
    input  logic                  ld_start_i,
    input  logic [31:0]           ld_wdata_i,
    input  logic                  ld_wvalid_i,
    input  logic                  ld_last_i,
    output logic                  ld_wready_o,
    output logic                  ld_done_o,
    output logic [DEPTH_LOG2:0]   ld_count_o,
    output logic                  busy_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mem_we;

    logic [31:0]             if_inst_q, if_inst_d;
    logic                    if_valid_q, if_valid_d;
    logic                    if_mis_q, if_mis_d;
    logic                    busy_q, wready_q, done_q;

    logic [31:0]             mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0]   word_idx;
    logic                    out_of_range;
    logic                    addr_misaligned;

    // Decode the fetch address into word index and validity flags.
    always_comb begin
        word_idx        = if_addr_i[DEPTH_LOG2+1:2];
        out_of_range    = (if_addr_i >> (DEPTH_LOG2 + 2)) != 32'd0;
        addr_misaligned = if_addr_i[1:0] != 2'b00;
    end

    // Load-session next state, write pointer and word counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (ld_start_i) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (ld_wvalid_i) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + DEPTH_LOG2'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                    // The last slot ends the session even without ld_last.
                    if (ld_last_i || (ptr_q == DEPTH_LOG2'(DEPTH - 1))) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Fetch path: stall holds, only RUN serves requests.
    always_comb begin
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        if_mis_d   = if_mis_q;
        if (!if_stall_i) begin
            if ((state_q == ST_RUN) && if_req_i) begin
                if_valid_d = 1'b1;
                if_mis_d   = addr_misaligned;
                if_inst_d  = (out_of_range || addr_misaligned) ? NOP_WORD : mem_q[word_idx];
            end else begin
                if_valid_d = 1'b0;
                if_mis_d   = 1'b0;
                if_inst_d  = NOP_WORD;
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_RUN;
            ptr_q      <= '0;
            cnt_q      <= '0;
            if_inst_q  <= NOP_WORD;
            if_valid_q <= 1'b0;
            if_mis_q   <= 1'b0;
            busy_q     <= 1'b0;
            wready_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            if_mis_q   <= if_mis_d;
            busy_q     <= (state_d == ST_LOAD);
            wready_q   <= (state_d == ST_LOAD);
            done_q     <= (state_d == ST_DONE);
        end
    end

    // Memory array; deliberately not reset so contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we && !reset_i) begin
            mem_q[ptr_q] <= ld_wdata_i;
        end
    end

    assign if_inst_o       = if_inst_q;
    assign if_valid_o      = if_valid_q;
    assign if_misaligned_o = if_mis_q;
    assign ld_wready_o     = wready_q;
    assign ld_done_o       = done_q;
    assign ld_count_o      = cnt_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Bench for inst_mem_loadable: directed scenarios followed by random traffic,
// each cycle checked against a behavioural model of the memory.
module tb_inst_mem_loadable;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_stall;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_misaligned;
    logic        ld_start;
    logic [31:0] ld_wdata;
    logic        ld_wvalid;
    logic        ld_last;
    logic        ld_wready;
    logic        ld_done;
    logic [8:0]  ld_count;
    logic        busy;

    inst_mem_loadable #(.DEPTH_LOG2(8), .NOP_WORD(NOP)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .if_req_i       (if_req),
        .if_addr_i      (if_addr),
        .if_stall_i     (if_stall),
        .if_inst_o      (if_inst),
        .if_valid_o     (if_valid),
        .if_misaligned_o(if_misaligned),
        .ld_start_i     (ld_start),
        .ld_wdata_i     (ld_wdata),
        .ld_wvalid_i    (ld_wvalid),
        .ld_last_i      (ld_last),
        .ld_wready_o    (ld_wready),
        .ld_done_o      (ld_done),
        .ld_count_o     (ld_count),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a word array plus "loading" / "just finished" flags.
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_loading, m_finishing;
    int          m_ptr;
    int          e_count;
    logic [31:0] e_inst;
    bit          e_inst_known;
    bit          e_valid, e_mis;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied,
    // clock the DUT, then compare every output.
    task automatic tick();
        int widx;
        if (reset) begin
            e_inst = NOP; e_inst_known = 1; e_valid = 0; e_mis = 0;
            m_loading = 0; m_finishing = 0; m_ptr = 0; e_count = 0;
        end else begin
            if (!if_stall) begin
                if (!m_loading && !m_finishing && if_req) begin
                    e_valid = 1;
                    e_mis   = (if_addr % 4) != 0;
                    if (e_mis || if_addr >= 32'(DEPTH * 4)) begin
                        e_inst = NOP; e_inst_known = 1;
                    end else begin
                        widx = int'(if_addr / 4);
                        e_inst = m_mem[widx]; e_inst_known = m_known[widx];
                    end
                end else begin
                    e_valid = 0; e_mis = 0; e_inst = NOP; e_inst_known = 1;
                end
            end
            if (m_finishing) begin
                m_finishing = 0;
            end else if (m_loading) begin
                if (ld_wvalid) begin
                    m_mem[m_ptr] = ld_wdata;
                    m_known[m_ptr] = 1;
                    m_ptr++;
                    e_count++;
                    if (ld_last || m_ptr == DEPTH) begin
                        m_loading = 0; m_finishing = 1;
                    end
                end
            end else if (ld_start) begin
                m_loading = 1; m_ptr = 0; e_count = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("if_valid", 32'(if_valid), 32'(e_valid));
        chk("if_misaligned", 32'(if_misaligned), 32'(e_mis));
        if (e_inst_known) chk("if_inst", if_inst, e_inst);
        chk("busy", 32'(busy), 32'(m_loading));
        chk("ld_wready", 32'(ld_wready), 32'(m_loading));
        chk("ld_done", 32'(ld_done), 32'(m_finishing));
        chk("ld_count", 32'(ld_count), 32'(e_count));
    endtask

    task automatic idle();
        reset = 0; if_req = 0; if_addr = 0; if_stall = 0;
        ld_start = 0; ld_wdata = 0; ld_wvalid = 0; ld_last = 0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        if_req = 1; if_addr = addr;
        tick();
        if_req = 0;
    endtask

    task automatic write_word(input logic [31:0] data, input bit last);
        ld_wvalid = 1; ld_wdata = data; ld_last = last;
        tick();
        ld_wvalid = 0; ld_last = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 0; m_mem[i] = '0;
        end
        m_loading = 0; m_finishing = 0; m_ptr = 0; e_count = 0;
        e_inst = NOP; e_inst_known = 1; e_valid = 0; e_mis = 0;
        idle();

        // Reset for two cycles, then a fetch from address 0.
        reset = 1;
        tick(); tick();
        reset = 0;
        fetch(32'h0);
        tick();

        // Three-word load ending with ld_last, fetched back.
        ld_start = 1; if_req = 1; if_addr = 32'h8;
        tick();
        ld_start = 0; if_req = 0;
        write_word(32'h0800_0010, 0);
        write_word(32'h0800_0030, 0);
        write_word(32'h03E0_0008, 1);
        tick();
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        chk("load3_word2", if_inst, 32'h03E0_0008);

        // Stall holds the served word while the address moves on.
        fetch(32'h4);
        if_req = 1; if_addr = 32'h8; if_stall = 1;
        tick(); tick(); tick();
        chk("stall_hold", if_inst, 32'h0800_0030);
        if_stall = 0;
        tick();
        chk("stall_release", if_inst, 32'h03E0_0008);
        if_req = 0;

        // Misaligned and out-of-range addresses.
        fetch(32'h0000_0402);
        fetch(32'h0000_0400);
        fetch(32'h8000_0000);
        fetch(32'h0000_03FE);

        // Full-depth load without ld_last, then extra writes are ignored.
        ld_start = 1;
        tick();
        ld_start = 0;
        for (int i = 0; i < DEPTH; i++) write_word(32'(i), 0);
        chk("full_count", 32'(ld_count), 32'd256);
        write_word(32'hDEAD_BEEF, 0);
        write_word(32'hDEAD_BEEF, 1);
        fetch(32'h3FC);
        chk("full_last_word", if_inst, 32'd255);
        fetch(32'h0);

        // Reset in the middle of a session.
        ld_start = 1;
        tick();
        ld_start = 0;
        for (int i = 0; i < 5; i++) write_word($urandom, 0);
        reset = 1;
        tick();
        reset = 0;
        fetch(32'h10);
        fetch(32'h14);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            if_req    = ($urandom_range(0, 9) < 7);
            if_stall  = ($urandom_range(0, 9) < 2);
            if_addr   = ($urandom_range(0, 19) == 0) ? $urandom
                                                     : 32'($urandom_range(0, 1023));
            ld_start  = ($urandom_range(0, 19) == 0);
            ld_wvalid = ($urandom_range(0, 1) == 1);
            ld_last   = ($urandom_range(0, 9) == 0);
            ld_wdata  = $urandom;
            tick();
        end
        idle();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
